// File: rtl/stage_retire_multi_pkg.sv
// stage_retire_multi_pkg
// Shared types and constants for the multi-wide retire stage: ROB head entry,
// commit debug packet, fetch redirect packet, retire FSM states, walk stop
// reasons and the branch mispredict rule.
package stage_retire_multi_pkg;

    localparam int ADDR_W             = 32;
    localparam int DATA_W             = 32;
    localparam int REG_IDX_W          = 5;
    localparam int ROB_IDX_W          = 5;
    localparam int RETIRE_N           = 4;
    localparam int PHYS_REG_SZ_R10K   = 64;
    localparam int PHYS_TAG_W         = $clog2(PHYS_REG_SZ_R10K);
    localparam int RETIRE_RECOVER_CYC = 2;
    localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {RS_RUN, RS_RECOVER, RS_HALTED} retire_state_e;

    // Why the lane walk ended this cycle.
    typedef enum logic [2:0] {
        SR_NONE, SR_BLOCKED, SR_INVALID, SR_INCOMPLETE,
        SR_SQ_BUSY, SR_ST_LIMIT, SR_EVENT
    } stop_reason_e;

    typedef struct packed {
        logic                  complete;
        logic                  halt;
        logic                  illegal;
        logic                  is_branch;
        logic                  pred_taken;
        logic                  taken;
        logic [ADDR_W-1:0]     pred_target;
        logic [ADDR_W-1:0]     branch_target;
        logic [ADDR_W-1:0]     pc;
        logic [REG_IDX_W-1:0]  arch_rd;
        logic [PHYS_TAG_W-1:0] phys_rd;
        logic [PHYS_TAG_W-1:0] prev_phys_rd;
    } rob_entry_t;

    typedef struct packed {
        logic [ADDR_W-1:0]    npc;
        logic [DATA_W-1:0]    data;
        logic [REG_IDX_W-1:0] reg_idx;
        logic                 halt;
        logic                 illegal;
        logic                 valid;
    } commit_packet_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] pc;
    } redirect_packet_t;

    // Wrong direction, or right direction (taken) but wrong target.
    function automatic logic is_mispredict(rob_entry_t e);
        return e.is_branch && ((e.taken != e.pred_taken) ||
                               (e.taken && (e.pred_target != e.branch_target)));
    endfunction

endpackage

// File: rtl/stage_retire_multi_select.sv
// stage_retire_multi_select
// Combinational retire-select: walks the head window from lane 0 and picks
// the contiguous committable prefix, with per-lane mispredict detect.
// Ports:
//   head_entries/head_valids/head_is_store  head window, lane 0 oldest
//   sq_ready      store buffer accepts commits
//   allow         walk enabled (RUN state, out of reset)
//   commit_mask   lanes committed this cycle (contiguous prefix)
//   store_mask    committed lanes that are stores
//   mispred_mask  per-lane mispredict detect (unqualified)
//   stop_reason   why the walk ended
//   event_lane    lane of the mispredict/halt/exception that ended the walk
module stage_retire_multi_select
    import stage_retire_multi_pkg::*;
#(
    parameter int RETIRE_W   = RETIRE_N,
    parameter int ST_PER_CYC = 1,
    parameter int LW         = (RETIRE_W > 1) ? $clog2(RETIRE_W) : 1
) (
    input  rob_entry_t [RETIRE_W-1:0] head_entries,
    input  logic [RETIRE_W-1:0]       head_valids,
    input  logic [RETIRE_W-1:0]       head_is_store,
    input  logic                      sq_ready,
    input  logic                      allow,
    output logic [RETIRE_W-1:0]       commit_mask,
    output logic [RETIRE_W-1:0]       store_mask,
    output logic [RETIRE_W-1:0]       mispred_mask,
    output stop_reason_e              stop_reason,
    output logic [LW-1:0]             event_lane
);

    always_comb begin
        for (int i = 0; i < RETIRE_W; i++)
            mispred_mask[i] = is_mispredict(head_entries[i]);
    end

    // Invalid lanes end the walk; nothing younger may be skipped to.
    always_comb begin
        int   st_cnt;
        logic go;
        commit_mask = '0;
        store_mask  = '0;
        event_lane  = '0;
        stop_reason = allow ? SR_NONE : SR_BLOCKED;
        go          = allow;
        st_cnt      = 0;
        for (int i = 0; i < RETIRE_W; i++) begin
            if (go) begin
                if (!head_valids[i]) begin
                    go = 1'b0; stop_reason = SR_INVALID;
                end else if (!head_entries[i].complete) begin
                    go = 1'b0; stop_reason = SR_INCOMPLETE;
                end else if (head_is_store[i] && !sq_ready) begin
                    go = 1'b0; stop_reason = SR_SQ_BUSY;
                end else if (head_is_store[i] && st_cnt >= ST_PER_CYC) begin
                    go = 1'b0; stop_reason = SR_ST_LIMIT;
                end else begin
                    commit_mask[i] = 1'b1;
                    store_mask[i]  = head_is_store[i];
                    if (head_is_store[i]) st_cnt = st_cnt + 1;
                    // Event lanes commit but end the window.
                    if (mispred_mask[i] || head_entries[i].halt || head_entries[i].illegal) begin
                        go          = 1'b0;
                        stop_reason = SR_EVENT;
                        event_lane  = LW'(i);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/stage_retire_multi.sv
// stage_retire_multi
// Multi-wide in-order retire stage with store throttling and a
// RUN/RECOVER/HALTED machine for mispredict recovery and halt.
// Optional macro RETIRE_PERF_EN adds saturating perf counters.
// Ports:
//   clock, reset_n          clock, async active-low reset
//   head_*                  ROB head window (lane 0 oldest)
//   sq_ready                store buffer accepts commits
//   regfile_entries         committed data for debug packets
//   retire_count            entries popped this cycle (comb)
//   sq_commit_count         stores released this cycle (comb)
//   arch_write_*            registered map-table writes
//   free_mask               registered Told frees
//   rob_mispredict/_idx     registered flush pulse and branch index
//   redirect_valid/_pc      registered fetch redirect
//   halted                  sticky halt
//   retire_commits_dbg      registered debug packets
//   perf_* (RETIRE_PERF_EN) retired/mispred/sq-stall/recover counters
module stage_retire_multi
    import stage_retire_multi_pkg::*;
#(
    parameter int RETIRE_W    = RETIRE_N,
    parameter int ST_PER_CYC  = 1,
    parameter int RECOVER_CYC = RETIRE_RECOVER_CYC,
    parameter int PHYS_REGS   = PHYS_REG_SZ_R10K,
    localparam int CW         = $clog2(RETIRE_W + 1)
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  rob_entry_t [RETIRE_W-1:0]            head_entries,
    input  logic [RETIRE_W-1:0]                  head_valids,
    input  logic [RETIRE_W-1:0][ROB_IDX_W-1:0]   head_idxs,
    input  logic [RETIRE_W-1:0]                  head_is_store,
    input  logic                                 sq_ready,
    input  logic [PHYS_REGS-1:0][DATA_W-1:0]     regfile_entries,
    output logic [CW-1:0]                        retire_count,
    output logic [CW-1:0]                        sq_commit_count,
    output logic [RETIRE_W-1:0]                  arch_write_enables,
    output logic [RETIRE_W-1:0][REG_IDX_W-1:0]   arch_write_addrs,
    output logic [RETIRE_W-1:0][PHYS_TAG_W-1:0]  arch_write_phys_regs,
    output logic [PHYS_REGS-1:0]                 free_mask,
    output logic                                 rob_mispredict,
    output logic [ROB_IDX_W-1:0]                 rob_mispred_idx,
    output logic                                 redirect_valid,
    output logic [ADDR_W-1:0]                    redirect_pc,
    output logic                                 halted,
    output commit_packet_t [RETIRE_W-1:0]        retire_commits_dbg
`ifdef RETIRE_PERF_EN
    ,
    output logic [63:0]                          perf_retired,
    output logic [31:0]                          perf_mispred,
    output logic [31:0]                          perf_sq_stall,
    output logic [31:0]                          perf_recover_cyc
`endif
);

    localparam int LW  = (RETIRE_W > 1) ? $clog2(RETIRE_W) : 1;
    localparam int RCW = $clog2(RECOVER_CYC + 1);

    retire_state_e           state;
    logic [RCW-1:0]          rcnt;
    logic [RETIRE_W-1:0]     commit_mask, store_mask, mispred_mask;
    stop_reason_e            stop_reason;
    logic [LW-1:0]           event_lane;
    logic                    allow;
    rob_entry_t              ev;
    logic                    ev_halt, ev_mispred;
    redirect_packet_t        redir_n, redir_q;

    logic [RETIRE_W-1:0]                 we_n;
    logic [RETIRE_W-1:0][REG_IDX_W-1:0]  wa_n;
    logic [RETIRE_W-1:0][PHYS_TAG_W-1:0] wp_n;
    logic [PHYS_REGS-1:0]                fm_n;
    commit_packet_t [RETIRE_W-1:0]       dbg_n;

    // Gating with reset_n keeps the comb counts at 0 while reset is held.
    assign allow = (state == RS_RUN) && reset_n;

    stage_retire_multi_select #(
        .RETIRE_W   (RETIRE_W),
        .ST_PER_CYC (ST_PER_CYC),
        .LW         (LW)
    ) u_select (
        .head_entries  (head_entries),
        .head_valids   (head_valids),
        .head_is_store (head_is_store),
        .sq_ready      (sq_ready),
        .allow         (allow),
        .commit_mask   (commit_mask),
        .store_mask    (store_mask),
        .mispred_mask  (mispred_mask),
        .stop_reason   (stop_reason),
        .event_lane    (event_lane)
    );

    always_comb begin
        retire_count    = '0;
        sq_commit_count = '0;
        for (int i = 0; i < RETIRE_W; i++) begin
            retire_count    = retire_count + CW'(commit_mask[i]);
            sq_commit_count = sq_commit_count + CW'(store_mask[i]);
        end
    end

    // Halt/exception outranks a mispredict on the same lane.
    assign ev         = head_entries[event_lane];
    assign ev_halt    = (stop_reason == SR_EVENT) && (ev.halt || ev.illegal);
    assign ev_mispred = (stop_reason == SR_EVENT) && !ev_halt && mispred_mask[event_lane];

    always_comb begin
        redir_n.valid = ev_mispred;
        redir_n.pc    = '0;
        if (ev_mispred)
            redir_n.pc = ev.taken ? ev.branch_target : ev.pc + ADDR_W'(4);
    end

    always_comb begin
        we_n  = '0;
        wa_n  = '0;
        wp_n  = '0;
        fm_n  = '0;
        dbg_n = '0;
        for (int i = 0; i < RETIRE_W; i++) begin
            if (commit_mask[i]) begin
                if (!head_entries[i].is_branch && head_entries[i].arch_rd != ZERO_REG) begin
                    we_n[i] = 1'b1;
                    wa_n[i] = head_entries[i].arch_rd;
                    wp_n[i] = head_entries[i].phys_rd;
                    if (head_entries[i].prev_phys_rd != '0)
                        fm_n[head_entries[i].prev_phys_rd] = 1'b1;
                end
                dbg_n[i].npc     = head_entries[i].pc + ADDR_W'(4);
                dbg_n[i].data    = regfile_entries[head_entries[i].phys_rd];
                dbg_n[i].reg_idx = head_entries[i].is_branch ? ZERO_REG : head_entries[i].arch_rd;
                dbg_n[i].halt    = head_entries[i].halt;
                dbg_n[i].illegal = head_entries[i].illegal;
                dbg_n[i].valid   = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state                <= RS_RUN;
            rcnt                 <= '0;
            arch_write_enables   <= '0;
            arch_write_addrs     <= '0;
            arch_write_phys_regs <= '0;
            free_mask            <= '0;
            retire_commits_dbg   <= '0;
            rob_mispredict       <= 1'b0;
            rob_mispred_idx      <= '0;
            redir_q              <= '0;
        end else begin
            arch_write_enables   <= we_n;
            arch_write_addrs     <= wa_n;
            arch_write_phys_regs <= wp_n;
            free_mask            <= fm_n;
            retire_commits_dbg   <= dbg_n;
            rob_mispredict       <= ev_mispred;
            rob_mispred_idx      <= ev_mispred ? head_idxs[event_lane] : '0;
            redir_q              <= redir_n;
            case (state)
                RS_RUN: begin
                    if (ev_halt) begin
                        state <= RS_HALTED;
                    end else if (ev_mispred) begin
                        state <= RS_RECOVER;
                        rcnt  <= RCW'(RECOVER_CYC);
                    end
                end
                RS_RECOVER: begin
                    if (rcnt <= RCW'(1)) begin
                        state <= RS_RUN;
                        rcnt  <= '0;
                    end else begin
                        rcnt  <= rcnt - RCW'(1);
                    end
                end
                default: state <= RS_HALTED;
            endcase
        end
    end

    assign redirect_valid = redir_q.valid;
    assign redirect_pc    = redir_q.pc;
    assign halted         = (state == RS_HALTED);

`ifdef RETIRE_PERF_EN
    logic [64:0] retired_sum;
    assign retired_sum = {1'b0, perf_retired} + 65'(retire_count);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_retired     <= '0;
            perf_mispred     <= '0;
            perf_sq_stall    <= '0;
            perf_recover_cyc <= '0;
        end else begin
            perf_retired <= retired_sum[64] ? '1 : retired_sum[63:0];
            if (ev_mispred && perf_mispred != '1)
                perf_mispred <= perf_mispred + 32'd1;
            if (stop_reason == SR_SQ_BUSY && perf_sq_stall != '1)
                perf_sq_stall <= perf_sq_stall + 32'd1;
            if (state == RS_RECOVER && perf_recover_cyc != '1)
                perf_recover_cyc <= perf_recover_cyc + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stage_retire_multi.sv
`timescale 1ns/1ps
module tb_stage_retire_multi;
    import stage_retire_multi_pkg::*;

    localparam int W   = 4;
    localparam int SPC = 1;
    localparam int RC  = 2;
    localparam int PR  = 64;
    localparam int CW  = 3;

    logic clock = 1'b0;
    logic reset_n = 1'b1;
    rob_entry_t [W-1:0]                head_entries;
    logic [W-1:0]                      head_valids, head_is_store;
    logic [W-1:0][ROB_IDX_W-1:0]       head_idxs;
    logic                              sq_ready;
    logic [PR-1:0][DATA_W-1:0]         regfile_entries;
    logic [CW-1:0]                     retire_count, sq_commit_count;
    logic [W-1:0]                      arch_write_enables;
    logic [W-1:0][REG_IDX_W-1:0]       arch_write_addrs;
    logic [W-1:0][PHYS_TAG_W-1:0]      arch_write_phys_regs;
    logic [PR-1:0]                     free_mask;
    logic                              rob_mispredict, redirect_valid, halted;
    logic [ROB_IDX_W-1:0]              rob_mispred_idx;
    logic [ADDR_W-1:0]                 redirect_pc;
    commit_packet_t [W-1:0]            retire_commits_dbg;

    stage_retire_multi #(.RETIRE_W(W), .ST_PER_CYC(SPC), .RECOVER_CYC(RC), .PHYS_REGS(PR)) dut (
        .clock(clock), .reset_n(reset_n),
        .head_entries(head_entries), .head_valids(head_valids), .head_idxs(head_idxs),
        .head_is_store(head_is_store), .sq_ready(sq_ready), .regfile_entries(regfile_entries),
        .retire_count(retire_count), .sq_commit_count(sq_commit_count),
        .arch_write_enables(arch_write_enables), .arch_write_addrs(arch_write_addrs),
        .arch_write_phys_regs(arch_write_phys_regs), .free_mask(free_mask),
        .rob_mispredict(rob_mispredict), .rob_mispred_idx(rob_mispred_idx),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halted(halted), .retire_commits_dbg(retire_commits_dbg)
    );

    always #5 clock = ~clock;

    // One expected observation: comb counts now plus registered outputs now.
    typedef struct packed {
        int                           rc;
        int                           sc;
        logic [W-1:0]                 we;
        logic [W-1:0][REG_IDX_W-1:0]  wa;
        logic [W-1:0][PHYS_TAG_W-1:0] wp;
        logic [PR-1:0]                fm;
        logic                         mp;
        logic [ROB_IDX_W-1:0]         mpi;
        logic                         rv;
        logic [ADDR_W-1:0]            rpc;
        logic                         h;
        commit_packet_t [W-1:0]       dbg;
    } exp_t;

    exp_t q[$];
    int   checks = 0, failures = 0;

    // Stimulus staging.
    rob_entry_t [W-1:0]          s_e;
    logic [W-1:0]                s_v, s_st;
    logic [W-1:0][ROB_IDX_W-1:0] s_idx;
    logic                        s_sq;

    // Reference model state.
    int   rec_left = 0;
    bit   mhalted  = 0;
    exp_t cur_reg  = '0;

    function automatic bit mispred(rob_entry_t x);
        if (!x.is_branch) return 0;
        if (x.taken != x.pred_taken) return 1;
        return x.taken && (x.pred_target != x.branch_target);
    endfunction

    function automatic bit is_event(rob_entry_t x);
        return x.halt || x.illegal || mispred(x);
    endfunction

    task automatic model_step(output exp_t e);
        exp_t nx;
        int n = 0, sc = 0;
        rob_entry_t last;
        if (!mhalted && rec_left == 0) begin
            for (int i = 0; i < W; i++) begin
                if (!s_v[i] || !s_e[i].complete) break;
                if (s_st[i] && (!s_sq || sc == SPC)) break;
                n++;
                if (s_st[i]) sc++;
                if (is_event(s_e[i])) break;
            end
        end
        e = cur_reg;
        e.rc = n;
        e.sc = sc;
        nx = '0;
        for (int i = 0; i < n; i++) begin
            if (!s_e[i].is_branch && s_e[i].arch_rd != 0) begin
                nx.we[i] = 1'b1;
                nx.wa[i] = s_e[i].arch_rd;
                nx.wp[i] = s_e[i].phys_rd;
                if (s_e[i].prev_phys_rd != 0) nx.fm[s_e[i].prev_phys_rd] = 1'b1;
            end
            nx.dbg[i].npc     = s_e[i].pc + 32'd4;
            nx.dbg[i].data    = regfile_entries[s_e[i].phys_rd];
            nx.dbg[i].reg_idx = s_e[i].is_branch ? 5'd0 : s_e[i].arch_rd;
            nx.dbg[i].halt    = s_e[i].halt;
            nx.dbg[i].illegal = s_e[i].illegal;
            nx.dbg[i].valid   = 1'b1;
        end
        if (rec_left > 0) rec_left--;
        if (n > 0) begin
            last = s_e[n-1];
            if (last.halt || last.illegal) begin
                mhalted = 1;
            end else if (mispred(last)) begin
                rec_left = RC;
                nx.mp  = 1'b1;
                nx.mpi = s_idx[n-1];
                nx.rv  = 1'b1;
                nx.rpc = last.taken ? last.branch_target : last.pc + 32'd4;
            end
        end
        nx.h = mhalted;
        cur_reg = nx;
    endtask

    task automatic apply();
        head_entries  = s_e;
        head_valids   = s_v;
        head_is_store = s_st;
        head_idxs     = s_idx;
        sq_ready      = s_sq;
        for (int r = 0; r < PR; r++) regfile_entries[r] = $urandom;
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clock);
        reset_n = 1'b1;
        apply();
        model_step(e);
        q.push_back(e);
    endtask

    // Reset asserted mid-cycle, away from any clock edge.
    task automatic tick_rst();
        @(negedge clock);
        apply();
        #1 reset_n = 1'b0;
        rec_left = 0;
        mhalted  = 0;
        cur_reg  = '0;
        q.push_back('0);
    endtask

    function automatic rob_entry_t alu(int rd, int ph, int prev);
        rob_entry_t x = '0;
        x.complete     = 1'b1;
        x.pc           = 32'h1000 + 32'(rd) * 4;
        x.arch_rd      = 5'(rd);
        x.phys_rd      = 6'(ph);
        x.prev_phys_rd = 6'(prev);
        return x;
    endfunction

    function automatic rob_entry_t rnd_lane(bit st);
        rob_entry_t x = '0;
        x.complete     = ($urandom % 6) != 0;
        x.pc           = $urandom & 32'hffff_fffc;
        x.arch_rd      = 5'($urandom_range(0, 31));
        x.phys_rd      = 6'($urandom_range(0, 63));
        x.prev_phys_rd = 6'($urandom_range(0, 63));
        if (!st && ($urandom % 5) == 0) begin
            x.is_branch     = 1'b1;
            x.taken         = 1'($urandom % 2);
            x.pred_taken    = (($urandom % 4) == 0) ? !x.taken : x.taken;
            x.branch_target = $urandom & 32'hffff_fffc;
            x.pred_target   = (($urandom % 4) == 0) ? x.branch_target + 32'd8 : x.branch_target;
        end
        x.halt    = ($urandom % 60) == 0;
        x.illegal = ($urandom % 100) == 0;
        return x;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    // Monitor: compares every observation the stimulus side queued.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #3;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("retire_count", 64'(retire_count), 64'(e.rc));
                chk("sq_commit_count", 64'(sq_commit_count), 64'(e.sc));
                chk("free_mask", free_mask, e.fm);
                chk("rob_mispredict", 64'(rob_mispredict), 64'(e.mp));
                chk("rob_mispred_idx", 64'(rob_mispred_idx), 64'(e.mpi));
                chk("redirect_valid", 64'(redirect_valid), 64'(e.rv));
                chk("redirect_pc", 64'(redirect_pc), 64'(e.rpc));
                chk("halted", 64'(halted), 64'(e.h));
                for (int i = 0; i < W; i++) begin
                    chk("arch_we", 64'(arch_write_enables[i]), 64'(e.we[i]));
                    chk("arch_addr", 64'(arch_write_addrs[i]), 64'(e.wa[i]));
                    chk("arch_phys", 64'(arch_write_phys_regs[i]), 64'(e.wp[i]));
                    chk("dbg_npc", 64'(retire_commits_dbg[i].npc), 64'(e.dbg[i].npc));
                    chk("dbg_data", 64'(retire_commits_dbg[i].data), 64'(e.dbg[i].data));
                    chk("dbg_flags",
                        64'({retire_commits_dbg[i].reg_idx, retire_commits_dbg[i].halt,
                             retire_commits_dbg[i].illegal, retire_commits_dbg[i].valid}),
                        64'({e.dbg[i].reg_idx, e.dbg[i].halt, e.dbg[i].illegal, e.dbg[i].valid}));
                end
            end
        end
    end

    initial begin
        s_e = '0; s_v = '0; s_st = '0; s_idx = '0; s_sq = 1'b1;
        apply();
        #1 reset_n = 1'b0;
        tick_rst();
        tick_rst();

        // Four complete ALU ops, rd 1..4, prev 10..13.
        for (int i = 0; i < W; i++) begin
            s_e[i] = alu(i + 1, 20 + i, 10 + i);
            s_idx[i] = 5'(i + 3);
        end
        s_v = '1;
        tick();
        // Lane 1 incomplete: only lane 0 retires.
        s_e[1].complete = 1'b0;
        tick();
        // Three stores, one per cycle; then store buffer busy.
        s_e[1].complete = 1'b1;
        s_st = 4'b0111;
        tick();
        s_sq = 1'b0;
        tick();
        s_sq = 1'b1;
        s_st = '0;
        // Lane 1 branch predicted NT, actually T to 0x400.
        s_e[1] = '0;
        s_e[1].complete = 1'b1; s_e[1].is_branch = 1'b1; s_e[1].pc = 32'h200;
        s_e[1].taken = 1'b1; s_e[1].branch_target = 32'h400;
        tick();
        repeat (3) tick();
        // Same branch correctly predicted.
        s_e[1].pred_taken = 1'b1; s_e[1].pred_target = 32'h400;
        repeat (3) tick();
        // Halt at lane 0.
        s_e[0].halt = 1'b1;
        repeat (4) tick();
        tick_rst();
        // Mispredict, then async reset while recovering.
        s_e[0].halt = 1'b0;
        s_e[1].pred_taken = 1'b0;
        tick();
        tick();
        tick_rst();
        repeat (2) tick();

        // Randomized windows.
        for (int c = 0; c < 1500; c++) begin
            if ((mhalted && ($urandom % 4) == 0) || ($urandom % 200) == 0) begin
                tick_rst();
            end else begin
                for (int i = 0; i < W; i++) begin
                    s_st[i]  = ($urandom % 4) == 0;
                    s_e[i]   = rnd_lane(s_st[i]);
                    s_v[i]   = ($urandom % 10) != 0;
                    s_idx[i] = 5'($urandom_range(0, 31));
                end
                s_sq = ($urandom % 10) < 7;
                tick();
            end
        end

        @(negedge clock);
        #5;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
